// File: rtl/player_motion_ctrl_if.sv
// player_motion_ctrl_if: raw button inputs and per-frame motion outputs of player_motion_ctrl.
// The master side is the motion controller; the slave side is the button source / sprite consumer.
interface player_motion_ctrl_if #(
    parameter int W  = 9,
    parameter int XW = 10
);
    logic                button_left;
    logic                button_right;
    logic                frame_tick;
    logic signed [W-1:0] delta_x;
    logic                delta_valid;
    logic [XW-1:0]       x_pos;

    modport master (
        input  button_left, button_right,
        output frame_tick, delta_x, delta_valid, x_pos
    );

    modport slave (
        output button_left, button_right,
        input  frame_tick, delta_x, delta_valid, x_pos
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: left/right buttons -> per-frame signed velocity with acceleration, friction and
// saturation, integrated into x_pos. Build option SCREEN_WRAP_EN: x_pos wraps at the screen edges instead of clamping.
module player_motion_ctrl #(
    parameter int CLK      = 50_000_000,
    parameter int FPS      = 50,
    parameter int W        = 9,
    parameter int ACCEL    = 2,
    parameter int FRICTION = 1,
    parameter int VMAX     = 16,
    parameter int SCREEN_W = 640,
    parameter int X_INIT   = 320
) (
    input  logic                 clk,
    input  logic                 rst,
    player_motion_ctrl_if.master bus
);

    localparam int PERIOD = CLK / FPS;
    localparam int CW     = $clog2(PERIOD);
    localparam int XW     = $clog2(SCREEN_W);
    localparam int SW     = ((XW > W) ? XW : W) + 2;

    if (PERIOD < 4) begin : g_period_check
        $error("player_motion_ctrl: CLK/FPS must be at least 4");
    end
    if (VMAX < 1 || VMAX > (2 ** (W - 1)) - 1) begin : g_vmax_check
        $error("player_motion_ctrl: VMAX must lie in 1 .. 2^(W-1)-1");
    end
    if (X_INIT < 0 || X_INIT >= SCREEN_W) begin : g_xinit_check
        $error("player_motion_ctrl: X_INIT must lie in 0 .. SCREEN_W-1");
    end

    typedef enum logic [1:0] {DIR_NONE, DIR_POS, DIR_NEG} dir_e;
    typedef logic signed [W:0] acc_t;

    // Steps larger than VMAX behave exactly like VMAX, so clipping them keeps every sum inside W+1 bits.
    localparam acc_t ACC_STEP  = acc_t'((ACCEL < VMAX) ? ACCEL : VMAX);
    localparam acc_t FRIC_STEP = acc_t'((FRICTION < VMAX) ? FRICTION : VMAX);
    localparam acc_t VMAX_S    = acc_t'(VMAX);
    localparam acc_t NEG_VMAX  = acc_t'(-VMAX);

    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(PERIOD - 2);
    localparam logic [XW-1:0] X_RESET  = XW'(X_INIT);

    logic [1:0]          sync_l;
    logic [1:0]          sync_r;
    logic [CW-1:0]       frame_cnt;
    logic                tick_q;
    logic                valid_q;
    logic signed [W-1:0] vel;
    logic [XW-1:0]       x_q;

    dir_e                dir;
    acc_t                vel_ext;
    acc_t                vel_mag;
    acc_t                vel_next;
    logic signed [SW-1:0] x_sum;
    logic [XW-1:0]       x_next;

    // Two-flop synchronizers for the asynchronous buttons.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync_l <= '0;
            sync_r <= '0;
        end else begin
            sync_l <= {sync_l[0], bus.button_left};
            sync_r <= {sync_r[0], bus.button_right};
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        dir = DIR_NONE;
        if (sync_r[1] && !sync_l[1]) begin
            dir = DIR_POS;
        end else if (sync_l[1] && !sync_r[1]) begin
            dir = DIR_NEG;
        end
    end

    always_comb begin
        vel_ext  = {vel[W-1], vel};
        vel_mag  = vel[W-1] ? -vel_ext : vel_ext;
        vel_next = vel_ext;
        unique case (dir)
            DIR_POS: begin
                if (vel[W-1]) begin
                    vel_next = ACC_STEP;
                end else if (vel_ext + ACC_STEP > VMAX_S) begin
                    vel_next = VMAX_S;
                end else begin
                    vel_next = vel_ext + ACC_STEP;
                end
            end
            DIR_NEG: begin
                if (!vel[W-1] && vel != '0) begin
                    vel_next = -ACC_STEP;
                end else if (vel_ext - ACC_STEP < NEG_VMAX) begin
                    vel_next = NEG_VMAX;
                end else begin
                    vel_next = vel_ext - ACC_STEP;
                end
            end
            default: begin
                // Friction pulls toward zero and never overshoots past it.
                if (vel_mag <= FRIC_STEP) begin
                    vel_next = '0;
                end else if (vel[W-1]) begin
                    vel_next = vel_ext + FRIC_STEP;
                end else begin
                    vel_next = vel_ext - FRIC_STEP;
                end
            end
        endcase
    end

`ifdef SCREEN_WRAP_EN
    localparam logic signed [SW-1:0] SCR_W_S = SW'(SCREEN_W);

    // One correction suffices because a single frame moves at most VMAX, which is below the screen width.
    always_comb begin
        x_sum  = $signed({{(SW - XW){1'b0}}, x_q}) + $signed({{(SW - W){vel[W-1]}}, vel});
        x_next = x_sum[XW-1:0];
        if (x_sum[SW-1]) begin
            x_next = XW'(x_sum + SCR_W_S);
        end else if (x_sum >= SCR_W_S) begin
            x_next = XW'(x_sum - SCR_W_S);
        end
    end
`else
    localparam logic signed [SW-1:0] SCR_MAX_S = SW'(SCREEN_W - 1);
    localparam logic [XW-1:0]        X_MAX     = XW'(SCREEN_W - 1);

    always_comb begin
        x_sum  = $signed({{(SW - XW){1'b0}}, x_q}) + $signed({{(SW - W){vel[W-1]}}, vel});
        x_next = x_sum[XW-1:0];
        if (x_sum[SW-1]) begin
            x_next = '0;
        end else if (x_sum > SCR_MAX_S) begin
            x_next = X_MAX;
        end
    end
`endif

    // frame_tick is registered one count early so it is high exactly while frame_cnt == PERIOD-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            tick_q    <= 1'b0;
            valid_q   <= 1'b0;
            vel       <= '0;
            x_q       <= X_RESET;
        end else begin
            frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
            tick_q    <= (frame_cnt == CNT_PRE);
            valid_q   <= tick_q;
            if (tick_q) begin
                vel <= vel_next[W-1:0];
            end
            if (valid_q) begin
                x_q <= x_next;
            end
        end
    end

    assign bus.frame_tick  = tick_q;
    assign bus.delta_valid = valid_q;
    assign bus.delta_x     = vel;
    assign bus.x_pos       = x_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: directed frames drive the buttons; a reference model pushes the expected
// delta_x / x_pos per frame into a queue that a negedge monitor pops on every delta_valid.
module tb_player_motion_ctrl;

    localparam int PERIOD   = 10;
    localparam int W        = 9;
    localparam int XW       = 6;
    localparam int ACCEL    = 2;
    localparam int FRICTION = 1;
    localparam int VMAX     = 6;
    localparam int SCREEN_W = 64;
    localparam int X_INIT   = 32;

    typedef struct {
        int dx;
        int x;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_vel;
    int   m_x;

    // Monitor state: what the outputs must hold right now.
    int   exp_dx_cur;
    int   exp_x_cur;
    int   exp_x_hold;
    logic pending_x;
    logic prev_tick;

    always #5 clk = ~clk;

    player_motion_ctrl_if #(.W(W), .XW(XW)) bus ();

    player_motion_ctrl #(
        .CLK      (100),
        .FPS      (10),
        .W        (W),
        .ACCEL    (ACCEL),
        .FRICTION (FRICTION),
        .VMAX     (VMAX),
        .SCREEN_W (SCREEN_W),
        .X_INIT   (X_INIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic void model_reset();
        m_vel = 0;
        m_x   = X_INIT;
    endfunction

    function automatic void model_push(input logic l, input logic r);
        int dir;
        int step;
        dir  = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        step = (ACCEL < VMAX) ? ACCEL : VMAX;
        if (dir == 1) begin
            m_vel = (m_vel < 0) ? step : ((m_vel + ACCEL > VMAX) ? VMAX : m_vel + ACCEL);
        end else if (dir == -1) begin
            m_vel = (m_vel > 0) ? -step : ((m_vel - ACCEL < -VMAX) ? -VMAX : m_vel - ACCEL);
        end else if (m_vel <= FRICTION && m_vel >= -FRICTION) begin
            m_vel = 0;
        end else begin
            m_vel = (m_vel > 0) ? m_vel - FRICTION : m_vel + FRICTION;
        end
`ifdef SCREEN_WRAP_EN
        m_x = ((m_x + m_vel) % SCREEN_W + SCREEN_W) % SCREEN_W;
`else
        m_x = m_x + m_vel;
        if (m_x < 0) m_x = 0;
        if (m_x > SCREEN_W - 1) m_x = SCREEN_W - 1;
`endif
        sb_q.push_back('{dx: m_vel, x: m_x});
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_dx_cur = 0;
            exp_x_cur  = X_INIT;
            pending_x  = 1'b0;
            prev_tick  = 1'b0;
        end else begin
            if (pending_x) begin
                exp_x_cur = exp_x_hold;
                pending_x = 1'b0;
            end
            if (bus.delta_valid === 1'b1) begin
                exp_t e;
                check("valid_follows_tick", prev_tick, 1);
                check("sb_nonempty", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e          = sb_q.pop_front();
                    exp_dx_cur = e.dx;
                    exp_x_hold = e.x;
                    pending_x  = 1'b1;
                end
            end
            check("delta_x", $signed(bus.delta_x), exp_dx_cur);
            check("x_pos", bus.x_pos, exp_x_cur);
            prev_tick = bus.frame_tick;
        end
    end

    task automatic check_reset_outputs();
        check("rst_delta_x", $signed(bus.delta_x), 0);
        check("rst_delta_valid", bus.delta_valid, 0);
        check("rst_x_pos", bus.x_pos, X_INIT);
        check("rst_frame_tick", bus.frame_tick, 0);
    endtask

    // Called at a negedge: sets buttons, pushes the frame's expectation, waits for the next tick.
    // exp_wait is PERIOD after a tick, PERIOD-1 when called in the first cycle after reset release.
    task automatic do_frame(input logic l, input logic r, input int exp_wait);
        int n;
        bus.button_left  = l;
        bus.button_right = r;
        model_push(l, r);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_tick !== 1'b1 && n < 4 * PERIOD);
        check("tick_spacing", n, exp_wait);
    endtask

    // Left held all frame; right asserted only during the cycle before the tick, so it must be ignored.
    task automatic pulse_frame();
        bus.button_left  = 1'b1;
        bus.button_right = 1'b0;
        model_push(1'b1, 1'b0);
        repeat (PERIOD - 1) @(negedge clk);
        bus.button_right = 1'b1;
        @(negedge clk);
        bus.button_right = 1'b0;
        check("pulse_tick_cycle", bus.frame_tick, 1);
    endtask

    initial begin
        rst              = 1'b1;
        bus.button_left  = 1'b0;
        bus.button_right = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Idle frames: first tick in the PERIOD-th cycle after release, velocity stays zero.
        do_frame(1'b0, 1'b0, PERIOD - 1);
        do_frame(1'b0, 1'b0, PERIOD);

        // Hold right: 2,4,6,6,6 with x 34,38,44,50,56.
        repeat (5) do_frame(1'b0, 1'b1, PERIOD);

        // Release: 5,4,3,2,1,0,0; x meets the right screen edge.
        repeat (7) do_frame(1'b0, 1'b0, PERIOD);

        // Right to vel 4, then both buttons -> 3.
        repeat (2) do_frame(1'b0, 1'b1, PERIOD);
        do_frame(1'b1, 1'b1, PERIOD);

        // Back to 6, then reversal: -2,-4,-6, pulse frame -6, then run into the left edge.
        repeat (2) do_frame(1'b0, 1'b1, PERIOD);
        repeat (3) do_frame(1'b1, 1'b0, PERIOD);
        pulse_frame();
        repeat (10) do_frame(1'b1, 1'b0, PERIOD);

        // Reversal from -6 to +6, then reset mid-frame at counter 5.
        repeat (3) do_frame(1'b0, 1'b1, PERIOD);
        repeat (6) @(negedge clk);
        rst              = 1'b1;
        bus.button_left  = 1'b0;
        bus.button_right = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        check("rst_sb_drained", sb_q.size(), 0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_frame(1'b0, 1'b0, PERIOD - 1);
        do_frame(1'b0, 1'b1, PERIOD);

        repeat (3) @(negedge clk);
        check("final_sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
